// File: rtl/sum_window_accum_pkg.sv
// sum_window_accum_pkg: state encoding and default sample width shared with the upstream adder
package sum_window_accum_pkg;
  localparam int DW_DEFAULT = 8;
  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;
endpackage

// File: rtl/sum_window_accum.sv
// sum_window_accum: accumulates 2**N_LOG2 samples and reports total, truncated average and maximum
module sum_window_accum
  import sum_window_accum_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int N_LOG2 = 2,
  localparam int ACC_W = DW + N_LOG2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CLEAR,
  input  logic             IN_VALID,
  input  logic [DW-1:0]    IN_DATA,
  output logic             IN_READY,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [ACC_W-1:0] OUT_TOTAL,
  output logic [DW-1:0]    OUT_AVG,
  output logic [DW-1:0]    OUT_MAX
);
  logic [0:0]        r_state;
  logic [ACC_W-1:0]  r_acc;
  logic [N_LOG2-1:0] r_cnt;
  logic [DW-1:0]     r_run_max;
  logic              r_out_valid;
  logic [ACC_W-1:0]  r_total;
  logic [DW-1:0]     r_avg;
  logic [DW-1:0]     r_max;
  logic              w_accept;
  logic              w_last;
  logic [ACC_W-1:0]  w_sum;
  logic [DW-1:0]     w_max;

  assign IN_READY  = (r_state == ST_ACCUM);
  assign OUT_VALID = r_out_valid;
  assign OUT_TOTAL = r_total;
  assign OUT_AVG   = r_avg;
  assign OUT_MAX   = r_max;
  assign w_accept  = IN_VALID & IN_READY;
  assign w_last    = w_accept & (r_cnt == '1);
  assign w_sum     = r_acc + ACC_W'(IN_DATA);
  assign w_max     = (IN_DATA > r_run_max) ? IN_DATA : r_run_max;

  // Window accumulation and ACCUM/HOLD sequencing; CLEAR beats accept and handshake
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= ST_ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_run_max   <= '0;
      r_out_valid <= 1'b0;
    end else if (CLEAR) begin
      r_state     <= ST_ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_run_max   <= '0;
      r_out_valid <= 1'b0;
    end else if (w_last) begin
      r_state     <= ST_HOLD;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_run_max   <= '0;
      r_out_valid <= 1'b1;
    end else if (w_accept) begin
      r_acc     <= w_sum;
      r_cnt     <= r_cnt + 1'b1;
      r_run_max <= w_max;
    end else if (r_out_valid && OUT_READY) begin
      r_state     <= ST_ACCUM;
      r_out_valid <= 1'b0;
    end
  end

  // Result data is captured on the last sample and kept until the next window; CLEAR leaves it alone
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_total <= '0;
      r_avg   <= '0;
      r_max   <= '0;
    end else if (!CLEAR && w_last) begin
      r_total <= w_sum;
      r_avg   <= w_sum[ACC_W-1:N_LOG2];
      r_max   <= w_max;
    end
  end
endmodule

// File: tb/tb_sum_window_accum.sv
// tb_sum_window_accum: directed windows with a queue scoreboard checked on every result handshake
module tb_sum_window_accum;
  typedef struct {
    logic [9:0] t;
    logic [7:0] a;
    logic [7:0] m;
  } exp_t;

  logic       CLK = 0;
  logic       RESET = 1;
  logic       CLEAR = 0;
  logic       IN_VALID = 0;
  logic [7:0] IN_DATA = 0;
  logic       IN_READY;
  logic       OUT_VALID;
  logic       OUT_READY = 1;
  logic [9:0] OUT_TOTAL;
  logic [7:0] OUT_AVG;
  logic [7:0] OUT_MAX;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  sum_window_accum dut (
    .CLK(CLK), .RESET(RESET), .CLEAR(CLEAR),
    .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_READY(IN_READY),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_TOTAL(OUT_TOTAL), .OUT_AVG(OUT_AVG), .OUT_MAX(OUT_MAX)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [9:0] t, input logic [7:0] a, input logic [7:0] m);
    exp_t e;
    e.t = t;
    e.a = a;
    e.m = m;
    q.push_back(e);
  endtask

  task automatic send(input logic [7:0] d);
    int n = 0;
    IN_VALID = 1;
    IN_DATA = d;
    @(negedge CLK);
    while (!IN_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!IN_READY) chk("accept_timeout", 0, 1);
    @(posedge CLK);
    #1 IN_VALID = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Monitor: every result handshake not overridden by CLEAR must match the oldest expectation
  always @(negedge CLK) begin
    if (!RESET && !CLEAR && OUT_VALID && OUT_READY) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_total", OUT_TOTAL, e.t);
        chk("sb_avg", OUT_AVG, e.a);
        chk("sb_max", OUT_MAX, e.m);
      end
    end
  end

  initial begin
    int n;
    repeat (2) @(posedge CLK);
    #1 RESET = 0;
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_in_ready", IN_READY, 1);
    chk("rst_total", OUT_TOTAL, 0);
    chk("rst_avg", OUT_AVG, 0);
    chk("rst_max", OUT_MAX, 0);

    push(100, 25, 40);
    send(10); send(20); send(30);
    chk("no_early_valid", OUT_VALID, 0);
    send(40);
    chk("latency_valid", OUT_VALID, 1);
    chk("hold_in_ready", IN_READY, 0);

    push(1020, 255, 255);
    send(255); send(255); send(255); send(255);

    idle(1);
    OUT_READY = 0;
    push(10, 2, 4);
    send(1); send(2); send(3); send(4);
    IN_VALID = 1;
    IN_DATA = 99;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("stall_valid", OUT_VALID, 1);
      chk("stall_in_ready", IN_READY, 0);
      chk("stall_total", OUT_TOTAL, 10);
    end
    @(posedge CLK);
    #1 IN_VALID = 0;
    OUT_READY = 1;
    @(posedge CLK);
    #1;
    chk("release_valid", OUT_VALID, 0);
    chk("release_in_ready", IN_READY, 1);

    push(20, 5, 9);
    send(7); idle(1); send(3); idle(2); send(9); send(1);

    send(50); send(60);
    #2 RESET = 1;
    #1;
    chk("arst_valid", OUT_VALID, 0);
    chk("arst_total", OUT_TOTAL, 0);
    chk("arst_avg", OUT_AVG, 0);
    chk("arst_max", OUT_MAX, 0);
    chk("arst_in_ready", IN_READY, 1);
    @(posedge CLK);
    #1 RESET = 0;
    push(10, 2, 4);
    send(1); send(2); send(3); send(4);

    send(5); send(5); send(5); send(5);
    chk("pre_clear_valid", OUT_VALID, 1);
    CLEAR = 1;
    @(posedge CLK);
    #1 CLEAR = 0;
    chk("clear_hold_valid", OUT_VALID, 0);
    chk("clear_hold_in_ready", IN_READY, 1);
    chk("clear_keeps_total", OUT_TOTAL, 20);
    send(100); send(100);
    CLEAR = 1;
    @(posedge CLK);
    #1 CLEAR = 0;
    push(4, 1, 1);
    send(1); send(1); send(1); send(1);

    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge CLK);
      n++;
    end
    #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
